// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master side issues operations and consumes results; the slave side is the unit.
interface muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output flush, in_valid, op, op_a, op_b, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, op, op_a, op_b, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M-style multiply/divide: magnitude shift-add / restoring divide over XLEN cycles,
// followed by one sign-correction cycle. Divide-by-zero and signed overflow short-circuit to DONE.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  opnd_q, opnd_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Request decode: signedness, magnitudes and the two early-exit cases
  logic            accept;
  logic            a_signed, b_signed;
  logic            in_neg_a, in_neg_b;
  logic [XLEN-1:0] in_mag_a, in_mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] exc_result;

  always_comb begin
    accept     = bus.in_valid & (state_q == IDLE) & ~bus.flush;
    a_signed   = (bus.op == 3'b000) | (bus.op == 3'b001) | (bus.op == 3'b010) |
                 (bus.op == 3'b100) | (bus.op == 3'b110);
    b_signed   = (bus.op == 3'b000) | (bus.op == 3'b001) |
                 (bus.op == 3'b100) | (bus.op == 3'b110);
    in_neg_a   = a_signed & bus.op_a[XLEN-1];
    in_neg_b   = b_signed & bus.op_b[XLEN-1];
    in_mag_a   = cond_neg(bus.op_a, in_neg_a);
    in_mag_b   = cond_neg(bus.op_b, in_neg_b);
    div_zero   = bus.op[2] & (bus.op_b == '0);
    div_ovf    = ((bus.op == 3'b100) | (bus.op == 3'b110)) &
                 (bus.op_a == MOST_NEG) & (bus.op_b == '1);
    if (div_zero) exc_result = bus.op[1] ? bus.op_a : '1;
    else          exc_result = bus.op[1] ? '0 : bus.op_a;
  end

  // One iteration: multiply shifts the product right, divide shifts the dividend left
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
  end

  // Sign correction and result selection for the FIX cycle
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  always_comb begin
    prod_fix = cond_neg_wide({hi_q, lo_q}, neg_a_q ^ neg_b_q);
    quo_fix  = cond_neg(lo_q, neg_a_q ^ neg_b_q);
    rem_fix  = cond_neg(hi_q, neg_a_q);
    case (op_q)
      3'b000:          fix_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:          fix_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:  fix_result = quo_fix;
      default:         fix_result = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    out_tag_d = out_tag_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = bus.op;
          neg_a_d = in_neg_a;
          neg_b_d = in_neg_b;
          tag_d   = bus.in_tag;
          cnt_d   = '0;
          hi_d    = '0;
          // Divide keeps the divisor and shifts the dividend; multiply keeps the multiplicand
          opnd_d  = bus.op[2] ? in_mag_b : in_mag_a;
          lo_d    = bus.op[2] ? in_mag_a : in_mag_b;
          if (div_zero | div_ovf) begin
            state_d   = DONE;
            result_d  = exc_result;
            out_tag_d = bus.in_tag;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
      end
      FIX: begin
        result_d  = fix_result;
        out_tag_d = tag_q;
        state_d   = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      tag_q     <= '0;
      cnt_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
      out_tag_q <= out_tag_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;
  assign bus.out_tag   = out_tag_q;

endmodule
